// File: rtl/axi4_ddr_rr_arbiter_pkg.sv
// axi4_ddr_rr_arbiter_pkg
//   Shared types and helpers for the two-port AXI4 DDR arbiter.
//   port_e   : requester index, also the MSB prepended to master-side IDs
//   lock_e   : per-channel grant lock state (AR and AW each own one)
//   rr_grant : round-robin pick shared by the AR and AW channels
package axi4_ddr_rr_arbiter_pkg;

    typedef enum logic {
        PORT_S0 = 1'b0,
        PORT_S1 = 1'b1
    } port_e;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_e;

    // Width of one route-FIFO entry (the port index of an accepted AW).
    localparam int unsigned ROUTE_WIDTH = 1;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_S0) ? PORT_S1 : PORT_S0;
    endfunction

    // Grant the valid port at or after ptr; with nothing valid, ptr is returned.
    function automatic port_e rr_grant(input logic v0, input logic v1, input port_e ptr);
        port_e g;
        g = ptr;
        if (ptr == PORT_S0) begin
            if (!v0 && v1) g = PORT_S1;
        end else begin
            if (!v1 && v0) g = PORT_S0;
        end
        return g;
    endfunction

endpackage

// File: rtl/axi4_ddr_rr_arbiter_route_fifo.sv
// arb_route_fifo
//   1-bit synchronous FIFO recording the port order of accepted AWs so that
//   W bursts are steered in the same order.
//   clock, reset : sys_clk, synchronous active-high reset (clears pointers)
//   push, din    : enqueue din (accepted while not full, or full with pop)
//   pop          : dequeue head (ignored when empty)
//   dout         : head entry; meaningful only while !empty
//   empty, full  : occupancy flags
module arb_route_fifo
    import axi4_ddr_rr_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ROUTE_WIDTH-1:0] din,
    output logic [ROUTE_WIDTH-1:0] dout,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty on wrap.
    logic [PW:0]            wr_ptr;
    logic [PW:0]            rd_ptr;
    logic [ROUTE_WIDTH-1:0] mem [DEPTH];
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop && !empty;
    // When full, the write slot is the head being popped this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/axi4_ddr_rr_arbiter.sv
// axi4_ddr_rr_arbiter
//   Two-requester AXI4 round-robin arbiter in front of the single DDR4 channel
//   (sys_clk domain). S0 = FireSim target memory, S1 = host/debug requester.
//   clock, reset   : sys_clk, synchronous active-high reset
//   s{0,1}_aw/w/ar : requester address/write channels (inputs, ready out)
//   s{0,1}_b/r     : responses routed back by master ID MSB
//   m_*            : master-side mirror; m_*_id = {port, s_*_id}
//   AR and AW arbitrate independently; W follows AW order via a route FIFO.
module axi4_ddr_rr_arbiter
    import axi4_ddr_rr_arbiter_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned WQ_DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    // S0
    input  logic                    s0_aw_valid,
    output logic                    s0_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   s0_aw_addr,
    input  logic [7:0]              s0_aw_len,
    input  logic [2:0]              s0_aw_size,
    input  logic [1:0]              s0_aw_burst,
    input  logic                    s0_aw_lock,
    input  logic [3:0]              s0_aw_cache,
    input  logic [2:0]              s0_aw_prot,
    input  logic [3:0]              s0_aw_qos,
    input  logic [ID_WIDTH-1:0]     s0_aw_id,
    input  logic                    s0_w_valid,
    output logic                    s0_w_ready,
    input  logic [DATA_WIDTH-1:0]   s0_w_data,
    input  logic [DATA_WIDTH/8-1:0] s0_w_strb,
    input  logic                    s0_w_last,
    output logic                    s0_b_valid,
    input  logic                    s0_b_ready,
    output logic [1:0]              s0_b_resp,
    output logic [ID_WIDTH-1:0]     s0_b_id,
    input  logic                    s0_ar_valid,
    output logic                    s0_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s0_ar_addr,
    input  logic [7:0]              s0_ar_len,
    input  logic [2:0]              s0_ar_size,
    input  logic [1:0]              s0_ar_burst,
    input  logic                    s0_ar_lock,
    input  logic [3:0]              s0_ar_cache,
    input  logic [2:0]              s0_ar_prot,
    input  logic [3:0]              s0_ar_qos,
    input  logic [ID_WIDTH-1:0]     s0_ar_id,
    output logic                    s0_r_valid,
    input  logic                    s0_r_ready,
    output logic [DATA_WIDTH-1:0]   s0_r_data,
    output logic [1:0]              s0_r_resp,
    output logic                    s0_r_last,
    output logic [ID_WIDTH-1:0]     s0_r_id,
    // S1
    input  logic                    s1_aw_valid,
    output logic                    s1_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   s1_aw_addr,
    input  logic [7:0]              s1_aw_len,
    input  logic [2:0]              s1_aw_size,
    input  logic [1:0]              s1_aw_burst,
    input  logic                    s1_aw_lock,
    input  logic [3:0]              s1_aw_cache,
    input  logic [2:0]              s1_aw_prot,
    input  logic [3:0]              s1_aw_qos,
    input  logic [ID_WIDTH-1:0]     s1_aw_id,
    input  logic                    s1_w_valid,
    output logic                    s1_w_ready,
    input  logic [DATA_WIDTH-1:0]   s1_w_data,
    input  logic [DATA_WIDTH/8-1:0] s1_w_strb,
    input  logic                    s1_w_last,
    output logic                    s1_b_valid,
    input  logic                    s1_b_ready,
    output logic [1:0]              s1_b_resp,
    output logic [ID_WIDTH-1:0]     s1_b_id,
    input  logic                    s1_ar_valid,
    output logic                    s1_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   s1_ar_addr,
    input  logic [7:0]              s1_ar_len,
    input  logic [2:0]              s1_ar_size,
    input  logic [1:0]              s1_ar_burst,
    input  logic                    s1_ar_lock,
    input  logic [3:0]              s1_ar_cache,
    input  logic [2:0]              s1_ar_prot,
    input  logic [3:0]              s1_ar_qos,
    input  logic [ID_WIDTH-1:0]     s1_ar_id,
    output logic                    s1_r_valid,
    input  logic                    s1_r_ready,
    output logic [DATA_WIDTH-1:0]   s1_r_data,
    output logic [1:0]              s1_r_resp,
    output logic                    s1_r_last,
    output logic [ID_WIDTH-1:0]     s1_r_id,
    // Master
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [ADDR_WIDTH-1:0]   m_aw_addr,
    output logic [7:0]              m_aw_len,
    output logic [2:0]              m_aw_size,
    output logic [1:0]              m_aw_burst,
    output logic                    m_aw_lock,
    output logic [3:0]              m_aw_cache,
    output logic [2:0]              m_aw_prot,
    output logic [3:0]              m_aw_qos,
    output logic [ID_WIDTH:0]       m_aw_id,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    output logic [DATA_WIDTH-1:0]   m_w_data,
    output logic [DATA_WIDTH/8-1:0] m_w_strb,
    output logic                    m_w_last,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    input  logic [1:0]              m_b_resp,
    input  logic [ID_WIDTH:0]       m_b_id,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    output logic [ADDR_WIDTH-1:0]   m_ar_addr,
    output logic [7:0]              m_ar_len,
    output logic [2:0]              m_ar_size,
    output logic [1:0]              m_ar_burst,
    output logic                    m_ar_lock,
    output logic [3:0]              m_ar_cache,
    output logic [2:0]              m_ar_prot,
    output logic [3:0]              m_ar_qos,
    output logic [ID_WIDTH:0]       m_ar_id,
    input  logic                    m_r_valid,
    output logic                    m_r_ready,
    input  logic [DATA_WIDTH-1:0]   m_r_data,
    input  logic [1:0]              m_r_resp,
    input  logic                    m_r_last,
    input  logic [ID_WIDTH:0]       m_r_id
);

    // ---------------- AR channel ----------------
    lock_e ar_state, ar_state_nxt;
    port_e ar_ptr, ar_ptr_nxt, ar_held, ar_held_nxt, ar_sel;
    logic  ar_s1;

    always_ff @(posedge clock) begin
        if (reset) begin
            ar_state <= ARB_OPEN;
            ar_ptr   <= PORT_S0;
            ar_held  <= PORT_S0;
        end else begin
            ar_state <= ar_state_nxt;
            ar_ptr   <= ar_ptr_nxt;
            ar_held  <= ar_held_nxt;
        end
    end

    always_comb begin
        ar_state_nxt = ar_state;
        ar_ptr_nxt   = ar_ptr;
        ar_held_nxt  = ar_held;
        if (m_ar_valid && m_ar_ready) begin
            ar_state_nxt = ARB_OPEN;
            ar_ptr_nxt   = other_port(ar_sel);
        end else if (m_ar_valid) begin
            ar_state_nxt = ARB_LOCKED;
            ar_held_nxt  = ar_sel;
        end
    end

    always_comb begin
        ar_sel      = (ar_state == ARB_LOCKED) ? ar_held : rr_grant(s0_ar_valid, s1_ar_valid, ar_ptr);
        ar_s1       = (ar_sel == PORT_S1);
        m_ar_valid  = !reset && (ar_s1 ? s1_ar_valid : s0_ar_valid);
        s0_ar_ready = m_ar_valid && !ar_s1 && m_ar_ready;
        s1_ar_ready = m_ar_valid &&  ar_s1 && m_ar_ready;
        m_ar_addr   = ar_s1 ? s1_ar_addr  : s0_ar_addr;
        m_ar_len    = ar_s1 ? s1_ar_len   : s0_ar_len;
        m_ar_size   = ar_s1 ? s1_ar_size  : s0_ar_size;
        m_ar_burst  = ar_s1 ? s1_ar_burst : s0_ar_burst;
        m_ar_lock   = ar_s1 ? s1_ar_lock  : s0_ar_lock;
        m_ar_cache  = ar_s1 ? s1_ar_cache : s0_ar_cache;
        m_ar_prot   = ar_s1 ? s1_ar_prot  : s0_ar_prot;
        m_ar_qos    = ar_s1 ? s1_ar_qos   : s0_ar_qos;
        m_ar_id     = {ar_s1, ar_s1 ? s1_ar_id : s0_ar_id};
    end

    // ---------------- AW channel ----------------
    lock_e aw_state, aw_state_nxt;
    port_e aw_ptr, aw_ptr_nxt, aw_held, aw_held_nxt, aw_sel;
    logic  aw_s1;
    logic  wq_push, wq_pop, wq_empty, wq_full;
    logic  [ROUTE_WIDTH-1:0] wq_head;

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_state <= ARB_OPEN;
            aw_ptr   <= PORT_S0;
            aw_held  <= PORT_S0;
        end else begin
            aw_state <= aw_state_nxt;
            aw_ptr   <= aw_ptr_nxt;
            aw_held  <= aw_held_nxt;
        end
    end

    // A FIFO-full stall drops m_aw_valid, so it never sets the lock by itself.
    always_comb begin
        aw_state_nxt = aw_state;
        aw_ptr_nxt   = aw_ptr;
        aw_held_nxt  = aw_held;
        if (m_aw_valid && m_aw_ready) begin
            aw_state_nxt = ARB_OPEN;
            aw_ptr_nxt   = other_port(aw_sel);
        end else if (m_aw_valid) begin
            aw_state_nxt = ARB_LOCKED;
            aw_held_nxt  = aw_sel;
        end
    end

    always_comb begin
        aw_sel      = (aw_state == ARB_LOCKED) ? aw_held : rr_grant(s0_aw_valid, s1_aw_valid, aw_ptr);
        aw_s1       = (aw_sel == PORT_S1);
        m_aw_valid  = !reset && (!wq_full || wq_pop) && (aw_s1 ? s1_aw_valid : s0_aw_valid);
        s0_aw_ready = m_aw_valid && !aw_s1 && m_aw_ready;
        s1_aw_ready = m_aw_valid &&  aw_s1 && m_aw_ready;
        m_aw_addr   = aw_s1 ? s1_aw_addr  : s0_aw_addr;
        m_aw_len    = aw_s1 ? s1_aw_len   : s0_aw_len;
        m_aw_size   = aw_s1 ? s1_aw_size  : s0_aw_size;
        m_aw_burst  = aw_s1 ? s1_aw_burst : s0_aw_burst;
        m_aw_lock   = aw_s1 ? s1_aw_lock  : s0_aw_lock;
        m_aw_cache  = aw_s1 ? s1_aw_cache : s0_aw_cache;
        m_aw_prot   = aw_s1 ? s1_aw_prot  : s0_aw_prot;
        m_aw_qos    = aw_s1 ? s1_aw_qos   : s0_aw_qos;
        m_aw_id     = {aw_s1, aw_s1 ? s1_aw_id : s0_aw_id};
        wq_push     = m_aw_valid && m_aw_ready;
    end

    arb_route_fifo #(
        .DEPTH (WQ_DEPTH)
    ) u_route_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wq_push),
        .pop   (wq_pop),
        .din   (aw_sel),
        .dout  (wq_head),
        .empty (wq_empty),
        .full  (wq_full)
    );

    // ---------------- W channel ----------------
    logic w_s1;

    always_comb begin
        w_s1       = (wq_head == PORT_S1);
        m_w_valid  = !reset && !wq_empty && (w_s1 ? s1_w_valid : s0_w_valid);
        m_w_data   = w_s1 ? s1_w_data : s0_w_data;
        m_w_strb   = w_s1 ? s1_w_strb : s0_w_strb;
        m_w_last   = w_s1 ? s1_w_last : s0_w_last;
        s0_w_ready = !reset && !wq_empty && !w_s1 && m_w_ready;
        s1_w_ready = !reset && !wq_empty &&  w_s1 && m_w_ready;
        wq_pop     = m_w_valid && m_w_ready && m_w_last;
    end

    // ---------------- R / B routing ----------------
    assign s0_r_valid = !reset && m_r_valid && !m_r_id[ID_WIDTH];
    assign s1_r_valid = !reset && m_r_valid &&  m_r_id[ID_WIDTH];
    assign m_r_ready  = !reset && (m_r_id[ID_WIDTH] ? s1_r_ready : s0_r_ready);
    assign s0_r_data  = m_r_data;
    assign s1_r_data  = m_r_data;
    assign s0_r_resp  = m_r_resp;
    assign s1_r_resp  = m_r_resp;
    assign s0_r_last  = m_r_last;
    assign s1_r_last  = m_r_last;
    assign s0_r_id    = m_r_id[ID_WIDTH-1:0];
    assign s1_r_id    = m_r_id[ID_WIDTH-1:0];

    assign s0_b_valid = !reset && m_b_valid && !m_b_id[ID_WIDTH];
    assign s1_b_valid = !reset && m_b_valid &&  m_b_id[ID_WIDTH];
    assign m_b_ready  = !reset && (m_b_id[ID_WIDTH] ? s1_b_ready : s0_b_ready);
    assign s0_b_resp  = m_b_resp;
    assign s1_b_resp  = m_b_resp;
    assign s0_b_id    = m_b_id[ID_WIDTH-1:0];
    assign s1_b_id    = m_b_id[ID_WIDTH-1:0];

endmodule

// File: tb/tb_axi4_ddr_rr_arbiter.sv
module tb_axi4_ddr_rr_arbiter;

    localparam int unsigned IDW = 16;
    localparam int unsigned AW  = 34;
    localparam int unsigned DW  = 64;
    localparam int unsigned WQ  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic s0_aw_valid, s0_aw_ready, s0_aw_lock, s1_aw_valid, s1_aw_ready, s1_aw_lock;
    logic [AW-1:0] s0_aw_addr, s1_aw_addr, s0_ar_addr, s1_ar_addr, m_aw_addr, m_ar_addr;
    logic [7:0] s0_aw_len, s1_aw_len, s0_ar_len, s1_ar_len, m_aw_len, m_ar_len;
    logic [2:0] s0_aw_size, s1_aw_size, s0_ar_size, s1_ar_size, m_aw_size, m_ar_size;
    logic [1:0] s0_aw_burst, s1_aw_burst, s0_ar_burst, s1_ar_burst, m_aw_burst, m_ar_burst;
    logic [3:0] s0_aw_cache, s1_aw_cache, s0_ar_cache, s1_ar_cache, m_aw_cache, m_ar_cache;
    logic [2:0] s0_aw_prot, s1_aw_prot, s0_ar_prot, s1_ar_prot, m_aw_prot, m_ar_prot;
    logic [3:0] s0_aw_qos, s1_aw_qos, s0_ar_qos, s1_ar_qos, m_aw_qos, m_ar_qos;
    logic [IDW-1:0] s0_aw_id, s1_aw_id, s0_ar_id, s1_ar_id, s0_b_id, s1_b_id, s0_r_id, s1_r_id;
    logic s0_w_valid, s0_w_ready, s0_w_last, s1_w_valid, s1_w_ready, s1_w_last;
    logic [DW-1:0] s0_w_data, s1_w_data, s0_r_data, s1_r_data, m_w_data, m_r_data;
    logic [DW/8-1:0] s0_w_strb, s1_w_strb, m_w_strb;
    logic s0_b_valid, s0_b_ready, s1_b_valid, s1_b_ready;
    logic [1:0] s0_b_resp, s1_b_resp, s0_r_resp, s1_r_resp, m_b_resp, m_r_resp;
    logic s0_ar_valid, s0_ar_ready, s0_ar_lock, s1_ar_valid, s1_ar_ready, s1_ar_lock;
    logic s0_r_valid, s0_r_ready, s0_r_last, s1_r_valid, s1_r_ready, s1_r_last;
    logic m_aw_valid, m_aw_ready, m_aw_lock, m_w_valid, m_w_ready, m_w_last;
    logic m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_ar_lock;
    logic m_r_valid, m_r_ready, m_r_last;
    logic [IDW:0] m_aw_id, m_b_id, m_ar_id, m_r_id;

    axi4_ddr_rr_arbiter #(
        .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WQ_DEPTH(WQ)
    ) dut (
        .clock(clock), .reset(reset),
        .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready), .s0_aw_addr(s0_aw_addr), .s0_aw_len(s0_aw_len),
        .s0_aw_size(s0_aw_size), .s0_aw_burst(s0_aw_burst), .s0_aw_lock(s0_aw_lock), .s0_aw_cache(s0_aw_cache),
        .s0_aw_prot(s0_aw_prot), .s0_aw_qos(s0_aw_qos), .s0_aw_id(s0_aw_id),
        .s0_w_valid(s0_w_valid), .s0_w_ready(s0_w_ready), .s0_w_data(s0_w_data), .s0_w_strb(s0_w_strb), .s0_w_last(s0_w_last),
        .s0_b_valid(s0_b_valid), .s0_b_ready(s0_b_ready), .s0_b_resp(s0_b_resp), .s0_b_id(s0_b_id),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(s0_ar_addr), .s0_ar_len(s0_ar_len),
        .s0_ar_size(s0_ar_size), .s0_ar_burst(s0_ar_burst), .s0_ar_lock(s0_ar_lock), .s0_ar_cache(s0_ar_cache),
        .s0_ar_prot(s0_ar_prot), .s0_ar_qos(s0_ar_qos), .s0_ar_id(s0_ar_id),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready), .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp),
        .s0_r_last(s0_r_last), .s0_r_id(s0_r_id),
        .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(s1_aw_addr), .s1_aw_len(s1_aw_len),
        .s1_aw_size(s1_aw_size), .s1_aw_burst(s1_aw_burst), .s1_aw_lock(s1_aw_lock), .s1_aw_cache(s1_aw_cache),
        .s1_aw_prot(s1_aw_prot), .s1_aw_qos(s1_aw_qos), .s1_aw_id(s1_aw_id),
        .s1_w_valid(s1_w_valid), .s1_w_ready(s1_w_ready), .s1_w_data(s1_w_data), .s1_w_strb(s1_w_strb), .s1_w_last(s1_w_last),
        .s1_b_valid(s1_b_valid), .s1_b_ready(s1_b_ready), .s1_b_resp(s1_b_resp), .s1_b_id(s1_b_id),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(s1_ar_addr), .s1_ar_len(s1_ar_len),
        .s1_ar_size(s1_ar_size), .s1_ar_burst(s1_ar_burst), .s1_ar_lock(s1_ar_lock), .s1_ar_cache(s1_ar_cache),
        .s1_ar_prot(s1_ar_prot), .s1_ar_qos(s1_ar_qos), .s1_ar_id(s1_ar_id),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready), .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp),
        .s1_r_last(s1_r_last), .s1_r_id(s1_r_id),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
        .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_lock(m_aw_lock), .m_aw_cache(m_aw_cache),
        .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_id(m_aw_id),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp), .m_b_id(m_b_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
        .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_lock(m_ar_lock), .m_ar_cache(m_ar_cache),
        .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
        .m_r_last(m_r_last), .m_r_id(m_r_id)
    );

    task automatic idle_inputs();
        {s0_aw_valid, s0_aw_lock, s1_aw_valid, s1_aw_lock, s0_ar_valid, s0_ar_lock, s1_ar_valid, s1_ar_lock} = '0;
        {s0_aw_addr, s1_aw_addr, s0_ar_addr, s1_ar_addr} = '0;
        {s0_aw_len, s1_aw_len, s0_ar_len, s1_ar_len} = '0;
        {s0_aw_size, s1_aw_size, s0_ar_size, s1_ar_size, s0_aw_prot, s1_aw_prot, s0_ar_prot, s1_ar_prot} = '0;
        {s0_aw_burst, s1_aw_burst, s0_ar_burst, s1_ar_burst} = '0;
        {s0_aw_cache, s1_aw_cache, s0_ar_cache, s1_ar_cache, s0_aw_qos, s1_aw_qos, s0_ar_qos, s1_ar_qos} = '0;
        {s0_aw_id, s1_aw_id, s0_ar_id, s1_ar_id} = '0;
        {s0_w_valid, s0_w_last, s1_w_valid, s1_w_last, s0_w_data, s1_w_data, s0_w_strb, s1_w_strb} = '0;
        {s0_b_ready, s1_b_ready, s0_r_ready, s1_r_ready} = '0;
        {m_aw_ready, m_w_ready, m_ar_ready, m_b_valid, m_b_resp, m_b_id} = '0;
        {m_r_valid, m_r_data, m_r_resp, m_r_last, m_r_id} = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Valids held through reset must not leak; first grants are S0 then S1.
    task automatic test_reset();
        logic [IDW:0] id;
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
        s0_aw_valid = 1'b1; m_aw_ready = 1'b1; m_r_valid = 1'b1; s0_r_ready = 1'b1;
        s0_ar_addr = 34'h0_0000_1000; s1_ar_addr = 34'h2_0000_2000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({m_ar_valid, s0_ar_ready, s1_ar_ready, m_aw_valid, s0_r_valid, m_r_ready} !== 6'b0) begin
                errors++; $display("FAIL reset_outputs cyc %0d got %b exp 000000", c,
                    {m_ar_valid, s0_ar_ready, s1_ar_ready, m_aw_valid, s0_r_valid, m_r_ready});
            end
            @(negedge clock);
        end
        idle_inputs();
        reset = 1'b0;
        s0_ar_valid = 1'b1; s1_ar_valid = 1'b1; m_ar_ready = 1'b1;
        s0_ar_addr = 34'h0_0000_1000; s1_ar_addr = 34'h2_0000_2000;
        #1; id = m_ar_id;
        checks++; if (m_ar_valid !== 1'b1 || id[IDW] !== 1'b0 || s0_ar_ready !== 1'b1) begin
            errors++; $display("FAIL reset_first_grant got v=%b port=%b rdy0=%b exp v=1 port=0 rdy0=1", m_ar_valid, id[IDW], s0_ar_ready);
        end
        @(negedge clock);
        s0_ar_valid = 1'b0;
        #1; id = m_ar_id;
        checks++; if (m_ar_valid !== 1'b1 || id[IDW] !== 1'b1 || m_ar_addr !== 34'h2_0000_2000) begin
            errors++; $display("FAIL reset_second_grant got v=%b port=%b addr=%h exp v=1 port=1 addr=200002000", m_ar_valid, id[IDW], m_ar_addr);
        end
    endtask

    // Both ports saturated: strict alternation with a handshake every cycle.
    task automatic test_ar_contention();
        int sent [2];
        logic [IDW:0] exp_id;
        apply_reset();
        sent[0] = 0; sent[1] = 0;
        s0_ar_id = 16'h00A0; s1_ar_id = 16'h00B1; m_ar_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s0_ar_valid = (sent[0] < 8); s1_ar_valid = (sent[1] < 8);
            s0_ar_addr = 34'(sent[0]) | 34'h0_1000_0000;
            s1_ar_addr = 34'(sent[1]) | 34'h1_2000_0000;
            #1;
            exp_id = (k % 2 == 0) ? {1'b0, 16'h00A0} : {1'b1, 16'h00B1};
            checks++; if (m_ar_valid !== 1'b1 || m_ar_id !== exp_id ||
                          m_ar_addr !== ((k % 2 == 0) ? s0_ar_addr : s1_ar_addr)) begin
                errors++; $display("FAIL contention k=%0d got v=%b id=%h addr=%h exp v=1 id=%h", k, m_ar_valid, m_ar_id, m_ar_addr, exp_id);
            end
            sent[k % 2]++;
            @(negedge clock);
        end
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
    endtask

    // Stalled S1 grant must stay put while S0 starts requesting.
    task automatic test_ar_stall();
        apply_reset();
        s1_ar_valid = 1'b1; s1_ar_addr = 34'h3_0000_0040; s1_ar_id = 16'h0ABC;
        s0_ar_addr = 34'h0_0000_0080; s0_ar_id = 16'h0123;
        m_ar_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) s0_ar_valid = 1'b1;
            #1;
            checks++; if (m_ar_valid !== 1'b1 || m_ar_id !== {1'b1, 16'h0ABC} || m_ar_addr !== 34'h3_0000_0040 || s0_ar_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold c=%0d got v=%b id=%h addr=%h exp v=1 id=10abc addr=300000040", c, m_ar_valid, m_ar_id, m_ar_addr);
            end
            @(negedge clock);
        end
        m_ar_ready = 1'b1;
        #1;
        checks++; if (s1_ar_ready !== 1'b1 || m_ar_id !== {1'b1, 16'h0ABC}) begin
            errors++; $display("FAIL stall_release got rdy1=%b id=%h exp rdy1=1 id=10abc", s1_ar_ready, m_ar_id);
        end
        @(negedge clock);
        s1_ar_valid = 1'b0;
        #1;
        checks++; if (m_ar_valid !== 1'b1 || m_ar_id !== {1'b0, 16'h0123} || s0_ar_ready !== 1'b1) begin
            errors++; $display("FAIL stall_next got v=%b id=%h exp v=1 id=00123", m_ar_valid, m_ar_id);
        end
        @(negedge clock);
        s0_ar_valid = 1'b0;
    endtask

    // Random AR traffic against a pending-request model.
    task automatic test_ar_random();
        bit pv [2];
        logic [AW-1:0] pa [2];
        logic [IDW-1:0] pid [2];
        logic [7:0] pl [2];
        int ptr, held, g;
        bit locked;
        logic [IDW:0] exp_id;
        apply_reset();
        ptr = 0; locked = 0; held = 0;
        pv[0] = 0; pv[1] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom % 3 != 0)) begin
                    pv[p] = 1; pa[p] = 34'({$urandom, $urandom}); pid[p] = 16'($urandom); pl[p] = 8'($urandom);
                end
            end
            s0_ar_valid = pv[0]; s0_ar_addr = pa[0]; s0_ar_id = pid[0]; s0_ar_len = pl[0];
            s1_ar_valid = pv[1]; s1_ar_addr = pa[1]; s1_ar_id = pid[1]; s1_ar_len = pl[1];
            m_ar_ready = 1'($urandom);
            if (locked) g = held;
            else if (pv[ptr]) g = ptr;
            else if (pv[1 - ptr]) g = 1 - ptr;
            else g = -1;
            #1;
            checks++; if (m_ar_valid !== (g >= 0)) begin
                errors++; $display("FAIL ar_rand_valid c=%0d got %b exp %b", c, m_ar_valid, (g >= 0));
            end
            if (g >= 0) begin
                exp_id = {g[0], pid[g]};
                checks++; if (m_ar_id !== exp_id || m_ar_addr !== pa[g] || m_ar_len !== pl[g]) begin
                    errors++; $display("FAIL ar_rand_fields c=%0d got id=%h addr=%h len=%h exp id=%h addr=%h len=%h",
                        c, m_ar_id, m_ar_addr, m_ar_len, exp_id, pa[g], pl[g]);
                end
            end
            checks++; if (s0_ar_ready !== (g == 0 && m_ar_ready) || s1_ar_ready !== (g == 1 && m_ar_ready)) begin
                errors++; $display("FAIL ar_rand_ready c=%0d got %b%b exp %b%b", c, s1_ar_ready, s0_ar_ready,
                    (g == 1 && m_ar_ready), (g == 0 && m_ar_ready));
            end
            if (g >= 0) begin
                if (m_ar_ready) begin pv[g] = 0; ptr = 1 - g; locked = 0; end
                else begin locked = 1; held = g; end
            end
            @(negedge clock);
        end
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
    endtask

    // S1's single beat, offered early, waits behind S0's 4-beat burst.
    task automatic test_write_order();
        bit aw_pend [2];
        int b0, b1;
        logic [DW:0] got_q [$];
        int aw_q [$];
        logic [DW:0] exp_beat [5];
        logic [IDW:0] awid;
        exp_beat[0] = {1'b0, 64'h100}; exp_beat[1] = {1'b0, 64'h101}; exp_beat[2] = {1'b0, 64'h102};
        exp_beat[3] = {1'b1, 64'h103}; exp_beat[4] = {1'b1, 64'h200};
        apply_reset();
        aw_pend[0] = 1; aw_pend[1] = 1; b0 = 0; b1 = 0;
        m_aw_ready = 1'b1; m_w_ready = 1'b1;
        s0_aw_len = 8'd3; s1_aw_len = 8'd0;
        for (int c = 0; c < 20 && got_q.size() < 5; c++) begin
            s0_aw_valid = aw_pend[0]; s1_aw_valid = aw_pend[1];
            s0_w_valid = (c >= 1 && b0 < 4); s0_w_data = 64'h100 + 64'(b0); s0_w_last = (b0 == 3);
            s1_w_valid = (b1 < 1); s1_w_data = 64'h200; s1_w_last = 1'b1;
            #1;
            if (b0 < 4) begin
                checks++; if (s1_w_ready !== 1'b0) begin
                    errors++; $display("FAIL w_order_s1_stall c=%0d got %b exp 0", c, s1_w_ready);
                end
            end
            if (m_aw_valid && m_aw_ready) begin awid = m_aw_id; aw_q.push_back(int'(awid[IDW])); end
            if (m_w_valid && m_w_ready) got_q.push_back({m_w_last, m_w_data});
            if (s0_aw_ready) aw_pend[0] = 0;
            if (s1_aw_ready) aw_pend[1] = 0;
            if (s0_w_valid && s0_w_ready) b0++;
            if (s1_w_valid && s1_w_ready) b1++;
            @(negedge clock);
        end
        idle_inputs();
        checks++; if (got_q.size() != 5 || aw_q.size() != 2) begin
            errors++; $display("FAIL w_order_count got beats=%0d aws=%0d exp beats=5 aws=2", got_q.size(), aw_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if (got_q[i] !== exp_beat[i]) begin
                errors++; $display("FAIL w_order_beat%0d got %h exp %h", i, got_q[i], exp_beat[i]);
            end
        end
        if (aw_q.size() == 2) begin
            checks++; if (aw_q[0] != 0 || aw_q[1] != 1) begin
                errors++; $display("FAIL w_order_aw got %0d,%0d exp 0,1", aw_q[0], aw_q[1]);
            end
        end
    endtask

    // Full route FIFO blocks the 5th AW until a W-last pop in the same cycle.
    task automatic test_fifo_full();
        apply_reset();
        m_aw_ready = 1'b1; m_w_ready = 1'b0; s0_aw_valid = 1'b1; s0_aw_id = 16'h0055;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 4) begin
                checks++; if (m_aw_valid !== 1'b1 || s0_aw_ready !== 1'b1) begin
                    errors++; $display("FAIL fifo_fill c=%0d got v=%b rdy=%b exp 1 1", c, m_aw_valid, s0_aw_ready);
                end
            end else begin
                checks++; if (m_aw_valid !== 1'b0 || s0_aw_ready !== 1'b0 || s1_aw_ready !== 1'b0) begin
                    errors++; $display("FAIL fifo_full_stall c=%0d got v=%b rdy=%b%b exp 0 00", c, m_aw_valid, s1_aw_ready, s0_aw_ready);
                end
            end
            @(negedge clock);
        end
        s0_w_valid = 1'b1; s0_w_last = 1'b1; m_w_ready = 1'b1;
        #1;
        checks++; if (m_w_valid !== 1'b1 || m_aw_valid !== 1'b1 || s0_aw_ready !== 1'b1) begin
            errors++; $display("FAIL fifo_pop_bypass got wv=%b awv=%b rdy=%b exp 1 1 1", m_w_valid, m_aw_valid, s0_aw_ready);
        end
        @(negedge clock);
        idle_inputs();
    endtask

    // Random AW + W traffic against a route-order queue model.
    task automatic test_aw_random();
        bit pv [2];
        logic [AW-1:0] pa [2];
        logic [IDW-1:0] pid [2];
        bit wv [2], wl [2];
        logic [DW-1:0] wd [2];
        int rq [$];
        int ptr, held, g, head;
        bit locked, ok, ewv, epop;
        logic [IDW:0] exp_id;
        apply_reset();
        ptr = 0; locked = 0; held = 0; pv[0] = 0; pv[1] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && ($urandom % 2 == 0)) begin
                    pv[p] = 1; pa[p] = 34'({$urandom, $urandom}); pid[p] = 16'($urandom);
                end
                wv[p] = 1'($urandom); wl[p] = 1'($urandom); wd[p] = {$urandom, $urandom};
            end
            s0_aw_valid = pv[0]; s0_aw_addr = pa[0]; s0_aw_id = pid[0];
            s1_aw_valid = pv[1]; s1_aw_addr = pa[1]; s1_aw_id = pid[1];
            s0_w_valid = wv[0]; s0_w_last = wl[0]; s0_w_data = wd[0];
            s1_w_valid = wv[1]; s1_w_last = wl[1]; s1_w_data = wd[1];
            m_aw_ready = 1'($urandom); m_w_ready = ($urandom % 4 != 0);
            head = (rq.size() > 0) ? rq[0] : -1;
            ewv  = (head >= 0) && wv[head];
            epop = ewv && m_w_ready && wl[head];
            ok   = (rq.size() < WQ) || epop;
            if (locked) g = held;
            else if (pv[ptr]) g = ptr;
            else if (pv[1 - ptr]) g = 1 - ptr;
            else g = -1;
            #1;
            checks++; if (m_aw_valid !== (g >= 0 && ok) || m_w_valid !== ewv) begin
                errors++; $display("FAIL aw_rand_valid c=%0d got aw=%b w=%b exp aw=%b w=%b", c, m_aw_valid, m_w_valid, (g >= 0 && ok), ewv);
            end
            if (g >= 0 && ok) begin
                exp_id = {g[0], pid[g]};
                checks++; if (m_aw_id !== exp_id || m_aw_addr !== pa[g]) begin
                    errors++; $display("FAIL aw_rand_fields c=%0d got id=%h addr=%h exp id=%h addr=%h", c, m_aw_id, m_aw_addr, exp_id, pa[g]);
                end
            end
            checks++; if (s0_aw_ready !== (g == 0 && ok && m_aw_ready) || s1_aw_ready !== (g == 1 && ok && m_aw_ready)) begin
                errors++; $display("FAIL aw_rand_ready c=%0d got %b%b exp %b%b", c, s1_aw_ready, s0_aw_ready,
                    (g == 1 && ok && m_aw_ready), (g == 0 && ok && m_aw_ready));
            end
            checks++; if (s0_w_ready !== (head == 0 && m_w_ready) || s1_w_ready !== (head == 1 && m_w_ready) ||
                          (ewv && m_w_data !== wd[head])) begin
                errors++; $display("FAIL w_rand_route c=%0d got rdy=%b%b data=%h exp head=%0d", c, s1_w_ready, s0_w_ready, m_w_data, head);
            end
            if (epop) void'(rq.pop_front());
            if (g >= 0 && ok) begin
                if (m_aw_ready) begin rq.push_back(g); pv[g] = 0; ptr = 1 - g; locked = 0; end
                else begin locked = 1; held = g; end
            end
            @(negedge clock);
        end
        idle_inputs();
    endtask

    // Responses route by ID MSB and never block on the other port.
    task automatic test_resp_routing();
        logic [IDW:0] id;
        bit p;
        apply_reset();
        m_r_valid = 1'b1; m_r_id = {1'b1, 16'h0005}; s1_r_ready = 1'b0; s0_r_ready = 1'b1;
        #1;
        checks++; if (s1_r_valid !== 1'b1 || s1_r_id !== 16'h0005 || s0_r_valid !== 1'b0 || m_r_ready !== 1'b0) begin
            errors++; $display("FAIL r_s1_blocked got v1=%b id=%h v0=%b mrdy=%b exp 1 0005 0 0", s1_r_valid, s1_r_id, s0_r_valid, m_r_ready);
        end
        @(negedge clock);
        m_r_id = {1'b0, 16'h0009};
        #1;
        checks++; if (s0_r_valid !== 1'b1 || s0_r_id !== 16'h0009 || s1_r_valid !== 1'b0 || m_r_ready !== 1'b1) begin
            errors++; $display("FAIL r_s0_pass got v0=%b id=%h v1=%b mrdy=%b exp 1 0009 0 1", s0_r_valid, s0_r_id, s1_r_valid, m_r_ready);
        end
        @(negedge clock);
        m_r_id = {1'b1, 16'h0005}; s1_r_ready = 1'b1;
        #1;
        checks++; if (s1_r_valid !== 1'b1 || m_r_ready !== 1'b1) begin
            errors++; $display("FAIL r_s1_release got v1=%b mrdy=%b exp 1 1", s1_r_valid, m_r_ready);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            m_r_valid = 1'($urandom); m_r_id = 17'($urandom); m_r_data = {$urandom, $urandom}; m_r_last = 1'($urandom);
            m_b_valid = 1'($urandom); m_b_id = 17'($urandom); m_b_resp = 2'($urandom);
            s0_r_ready = 1'($urandom); s1_r_ready = 1'($urandom); s0_b_ready = 1'($urandom); s1_b_ready = 1'($urandom);
            #1;
            id = m_r_id; p = id[IDW];
            checks++; if (s0_r_valid !== (m_r_valid && !p) || s1_r_valid !== (m_r_valid && p) ||
                          m_r_ready !== (p ? s1_r_ready : s0_r_ready) ||
                          (p ? s1_r_id : s0_r_id) !== id[IDW-1:0] || (p ? s1_r_data : s0_r_data) !== m_r_data) begin
                errors++; $display("FAIL r_rand i=%0d got v=%b%b mrdy=%b exp port=%b", i, s1_r_valid, s0_r_valid, m_r_ready, p);
            end
            id = m_b_id; p = id[IDW];
            checks++; if (s0_b_valid !== (m_b_valid && !p) || s1_b_valid !== (m_b_valid && p) ||
                          m_b_ready !== (p ? s1_b_ready : s0_b_ready) ||
                          (p ? s1_b_id : s0_b_id) !== id[IDW-1:0] || (p ? s1_b_resp : s0_b_resp) !== m_b_resp) begin
                errors++; $display("FAIL b_rand i=%0d got v=%b%b mrdy=%b exp port=%b", i, s1_b_valid, s0_b_valid, m_b_ready, p);
            end
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_ar_contention();
        test_ar_stall();
        test_ar_random();
        test_write_order();
        test_fifo_full();
        test_aw_random();
        test_resp_routing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
